// File: rtl/laser_pkg.sv
// rtl/laser_pkg.sv - shared types and constants for the two-circle laser search sequencer
package laser_pkg;

    localparam int GRID_W     = 4;
    localparam int HIT_W      = 6;
    localparam int NUM_PTS    = 40;
    localparam int MAX_ROUNDS = 8;
    localparam int PT_AW      = 6;

    typedef enum logic [2:0] {
        LOAD,
        INIT,
        START,
        WAIT,
        END_SWEEP,
        FINISH
    } state_t;

    typedef enum logic {
        SEL_C1,
        SEL_C2
    } sel_t;

    typedef struct packed {
        logic [GRID_W-1:0] x;
        logic [GRID_W-1:0] y;
    } coord_t;

    localparam coord_t C1_INIT = '{x: 4'd0,  y: 4'd0};
    localparam coord_t C2_INIT = '{x: 4'd15, y: 4'd15};

endpackage

// File: rtl/laser_search_ctrl_if.sv
// rtl/laser_search_ctrl_if.sv - point-load and hit-count engine handshake bundle
interface laser_search_ctrl_if #(
    parameter int HIT_W = laser_pkg::HIT_W
);
    logic             pt_wr_en;
    logic [5:0]       pt_wr_addr;
    logic [3:0]       pt_wr_x;
    logic [3:0]       pt_wr_y;
    logic             eng_start;
    logic [3:0]       eng_cx;
    logic [3:0]       eng_cy;
    logic [3:0]       eng_fx;
    logic [3:0]       eng_fy;
    logic             eng_done;
    logic [HIT_W-1:0] eng_hits;

    modport master (
        output pt_wr_en, pt_wr_addr, pt_wr_x, pt_wr_y,
        output eng_start, eng_cx, eng_cy, eng_fx, eng_fy,
        input  eng_done, eng_hits
    );

    modport slave (
        input  pt_wr_en, pt_wr_addr, pt_wr_x, pt_wr_y,
        input  eng_start, eng_cx, eng_cy, eng_fx, eng_fy,
        output eng_done, eng_hits
    );

endinterface

// File: rtl/laser_best_tracker.sv
// rtl/laser_best_tracker.sv - best hit count and its centre within one sweep
module laser_best_tracker
    import laser_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             clear,
    input  coord_t           clear_xy,
    input  logic             sample,
    input  logic [CNT_W-1:0] hits,
    input  coord_t           cand_xy,
    output logic [CNT_W-1:0] best,
    output coord_t           best_xy
);

    // Strictly greater, so among equal scores the earliest candidate is kept.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            best    <= '0;
            best_xy <= '0;
        end else if (clear) begin
            best    <= '0;
            best_xy <= clear_xy;
        end else if (sample && (hits > best)) begin
            best    <= hits;
            best_xy <= cand_xy;
        end
    end

endmodule

// File: rtl/laser_search_ctrl.sv
// rtl/laser_search_ctrl.sv - loads target points, then alternates C1/C2 grid sweeps until no improvement
module laser_search_ctrl #(
    parameter int NUM_PTS    = laser_pkg::NUM_PTS,
    parameter int MAX_ROUNDS = laser_pkg::MAX_ROUNDS,
    parameter int HIT_W      = laser_pkg::HIT_W
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [3:0]          X,
    input  logic [3:0]          Y,
    laser_search_ctrl_if.master eng,
    output logic [3:0]          C1X,
    output logic [3:0]          C1Y,
    output logic [3:0]          C2X,
    output logic [3:0]          C2Y,
    output logic                DONE
);
    import laser_pkg::*;

    localparam int ROUND_W = $clog2(MAX_ROUNDS + 1);

    state_t             state;
    sel_t               sel;
    logic [PT_AW-1:0]   load_cnt;
    logic [7:0]         scan;
    logic [ROUND_W-1:0] round;
    logic               improved;
    logic [HIT_W-1:0]   global_best;
    coord_t             c1;
    coord_t             c2;

    logic [HIT_W-1:0]   sweep_best;
    coord_t             sweep_xy;
    logic               trk_clear;
    logic               trk_sample;
    coord_t             trk_clear_xy;
    coord_t             scan_xy;

    logic               gain;
    logic               improved_now;
    logic [ROUND_W-1:0] round_inc;
    logic               last_round;

    assign scan_xy      = '{x: scan[3:0], y: scan[7:4]};
    assign trk_sample   = (state == WAIT) && eng.eng_done;
    assign trk_clear    = (state == INIT) || (state == END_SWEEP);
    // On a clear the sweep defaults to the centre that is about to be swept.
    assign trk_clear_xy = (state == INIT) ? C1_INIT : ((sel == SEL_C1) ? c2 : c1);

    assign gain         = sweep_best > global_best;
    assign improved_now = improved | gain;
    assign round_inc    = round + 1'b1;
    assign last_round   = (round_inc == ROUND_W'(MAX_ROUNDS));

    laser_best_tracker #(
        .CNT_W (HIT_W)
    ) u_tracker (
        .CLK      (CLK),
        .RST      (RST),
        .clear    (trk_clear),
        .clear_xy (trk_clear_xy),
        .sample   (trk_sample),
        .hits     (eng.eng_hits),
        .cand_xy  (scan_xy),
        .best     (sweep_best),
        .best_xy  (sweep_xy)
    );

    assign C1X = c1.x;
    assign C1Y = c1.y;
    assign C2X = c2.x;
    assign C2Y = c2.y;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state          <= LOAD;
            sel            <= SEL_C1;
            load_cnt       <= '0;
            scan           <= '0;
            round          <= '0;
            improved       <= 1'b0;
            global_best    <= '0;
            c1             <= '0;
            c2             <= '0;
            DONE           <= 1'b0;
            eng.pt_wr_en   <= 1'b0;
            eng.pt_wr_addr <= '0;
            eng.pt_wr_x    <= '0;
            eng.pt_wr_y    <= '0;
            eng.eng_start  <= 1'b0;
            eng.eng_cx     <= '0;
            eng.eng_cy     <= '0;
            eng.eng_fx     <= '0;
            eng.eng_fy     <= '0;
        end else begin
            eng.pt_wr_en  <= 1'b0;
            eng.eng_start <= 1'b0;
            unique case (state)
                LOAD: begin
                    eng.pt_wr_en   <= 1'b1;
                    eng.pt_wr_addr <= load_cnt;
                    eng.pt_wr_x    <= X;
                    eng.pt_wr_y    <= Y;
                    if (load_cnt == PT_AW'(NUM_PTS - 1)) begin
                        load_cnt <= '0;
                        state    <= INIT;
                    end else begin
                        load_cnt <= load_cnt + 1'b1;
                    end
                end
                INIT: begin
                    c1          <= C1_INIT;
                    c2          <= C2_INIT;
                    global_best <= '0;
                    round       <= '0;
                    sel         <= SEL_C1;
                    improved    <= 1'b0;
                    scan        <= '0;
                    state       <= START;
                end
                START: begin
                    eng.eng_start <= 1'b1;
                    eng.eng_cx    <= scan[3:0];
                    eng.eng_cy    <= scan[7:4];
                    eng.eng_fx    <= (sel == SEL_C1) ? c2.x : c1.x;
                    eng.eng_fy    <= (sel == SEL_C1) ? c2.y : c1.y;
                    state         <= WAIT;
                end
                WAIT: begin
                    if (eng.eng_done) begin
                        if (scan == 8'hFF) begin
                            state <= END_SWEEP;
                        end else begin
                            scan  <= scan + 8'd1;
                            state <= START;
                        end
                    end
                end
                END_SWEEP: begin
                    if (gain) begin
                        global_best <= sweep_best;
                        if (sel == SEL_C1) c1 <= sweep_xy;
                        else               c2 <= sweep_xy;
                    end
                    scan <= '0;
                    if (sel == SEL_C1) begin
                        sel      <= SEL_C2;
                        improved <= improved_now;
                        state    <= START;
                    end else begin
                        round <= round_inc;
                        if (!improved_now || last_round) begin
                            DONE  <= 1'b1;
                            state <= FINISH;
                        end else begin
                            improved <= 1'b0;
                            sel      <= SEL_C1;
                            state    <= START;
                        end
                    end
                end
                FINISH: begin
                    DONE <= 1'b1;
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_laser_search_ctrl.sv
// tb/tb_laser_search_ctrl.sv - scoreboard bench with a behavioural search model and engine stub
module tb_laser_search_ctrl;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] X = '0;
    logic [3:0] Y = '0;
    logic [3:0] C1X, C1Y, C2X, C2Y;
    logic       DONE;

    laser_search_ctrl_if #(.HIT_W(6)) bus ();

    laser_search_ctrl #(
        .NUM_PTS    (40),
        .MAX_ROUNDS (8),
        .HIT_W      (6)
    ) dut (
        .CLK  (CLK),
        .RST  (RST),
        .X    (X),
        .Y    (Y),
        .eng  (bus),
        .C1X  (C1X),
        .C1Y  (C1Y),
        .C2X  (C2X),
        .C2Y  (C2Y),
        .DONE (DONE)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int a;
        int b;
        int c;
        int d;
        int e;
    } rec_t;

    rec_t exp_wr[$];
    rec_t exp_op[$];
    rec_t exp_fin[$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int mon_starts;
    bit done_seen;
    int mode;
    int max_lat;
    bit spurious_en;
    int pt_x[40];
    int pt_y[40];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Engine scoring rules per test mode; sweep is the 0-based sweep number.
    function automatic int hit_fn(input int m, input int cx, input int cy,
                                  input int fx, input int fy, input int sweep);
        case (m)
            0:       return (cx == 5 && cy == 7 && fx == 15 && fy == 15) ? 10 : 0;
            1:       return ((cx == 3 && cy == 3) || (cx == 9 && cy == 9)) ? 7 : 0;
            2:       return (cx == sweep % 16 && cy == 3) ? sweep + 1 : 0;
            default: return (cx * 37 + cy * 11 + fx * 5 + fy * 3 + cx * fy) % 41;
        endcase
    endfunction

    // Reference search: plain loops over rounds, circles and grid points.
    task automatic build_expected(input int m);
        int c[2][2];
        int gb, sweep, improved, best, bx, by, fx, fy, h;
        c[0][0] = 0;  c[0][1] = 0;
        c[1][0] = 15; c[1][1] = 15;
        gb = 0;
        sweep = 0;
        for (int r = 0; r < 8; r++) begin
            improved = 0;
            for (int s = 0; s < 2; s++) begin
                fx = c[1-s][0];
                fy = c[1-s][1];
                best = 0;
                bx = c[s][0];
                by = c[s][1];
                for (int y = 0; y < 16; y++) begin
                    for (int x = 0; x < 16; x++) begin
                        exp_op.push_back('{x, y, fx, fy, 0});
                        h = hit_fn(m, x, y, fx, fy, sweep);
                        if (h > best) begin
                            best = h;
                            bx = x;
                            by = y;
                        end
                    end
                end
                sweep++;
                if (best > gb) begin
                    gb = best;
                    c[s][0] = bx;
                    c[s][1] = by;
                    improved = 1;
                end
            end
            if (improved == 0) break;
        end
        exp_fin.push_back('{c[0][0], c[0][1], c[1][0], c[1][1], sweep * 256});
    endtask

    always @(posedge CLK or posedge RST) begin
        if (RST) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Engine stub: scores on eng_start, answers after 1..max_lat cycles.
    initial begin : engine
        int busy;
        int pend;
        int eng_starts;
        busy = 0;
        pend = 0;
        eng_starts = 0;
        bus.eng_done = 1'b0;
        bus.eng_hits = '0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                busy = 0;
                eng_starts = 0;
                bus.eng_done = 1'b0;
                bus.eng_hits = '0;
            end else begin
                bus.eng_done = 1'b0;
                if (busy > 0) begin
                    busy--;
                    if (busy == 0) begin
                        bus.eng_done = 1'b1;
                        bus.eng_hits = 6'(pend);
                    end
                end else if (bus.eng_start) begin
                    pend = hit_fn(mode, bus.eng_cx, bus.eng_cy, bus.eng_fx, bus.eng_fy,
                                  eng_starts / 256);
                    eng_starts++;
                    busy = $urandom_range(max_lat, 1);
                end else if (spurious_en && $urandom_range(3, 0) == 0) begin
                    bus.eng_done = 1'b1;
                    bus.eng_hits = 6'd63;
                end
            end
        end
    end

    initial begin : monitor
        rec_t r;
        forever begin
            @(negedge CLK);
            if (!RST) begin
                if (bus.pt_wr_en) begin
                    if (exp_wr.size() == 0) begin
                        check("wr_unexpected", 1, 0);
                    end else begin
                        r = exp_wr.pop_front();
                        check("wr_addr", bus.pt_wr_addr, r.a);
                        check("wr_xy", {bus.pt_wr_x, bus.pt_wr_y}, r.b * 16 + r.c);
                        check("wr_cycle", cyc, r.a + 1);
                    end
                end
                if (bus.eng_start) begin
                    mon_starts++;
                    if (mon_starts == 1) check("first_start_cycle", cyc, 42);
                    if (exp_op.size() == 0) begin
                        check("start_unexpected", 1, 0);
                    end else begin
                        r = exp_op.pop_front();
                        check("operands", {bus.eng_cx, bus.eng_cy, bus.eng_fx, bus.eng_fy},
                              (r.a << 12) | (r.b << 8) | (r.c << 4) | r.d);
                    end
                end
                if (DONE && !done_seen) begin
                    done_seen = 1;
                    if (exp_fin.size() == 0) begin
                        check("done_unexpected", 1, 0);
                    end else begin
                        r = exp_fin.pop_front();
                        check("final_c1", {C1X, C1Y}, r.a * 16 + r.b);
                        check("final_c2", {C2X, C2Y}, r.c * 16 + r.d);
                        check("final_starts", mon_starts, r.e);
                    end
                end
                if (DONE) check("start_after_done", bus.eng_start, 0);
            end
        end
    end

    task automatic start_test(input int m, input int lat, input bit spur);
        RST = 1'b1;
        mode = m;
        max_lat = lat;
        spurious_en = spur;
        exp_wr.delete();
        exp_op.delete();
        exp_fin.delete();
        mon_starts = 0;
        done_seen = 0;
        @(negedge CLK);
        check("rst_wr", {bus.pt_wr_en, bus.pt_wr_addr, bus.pt_wr_x, bus.pt_wr_y}, 0);
        check("rst_eng", {bus.eng_start, bus.eng_cx, bus.eng_cy, bus.eng_fx, bus.eng_fy}, 0);
        check("rst_out", {C1X, C1Y, C2X, C2Y, DONE}, 0);
        for (int i = 0; i < 40; i++) begin
            pt_x[i] = $urandom_range(15, 0);
            pt_y[i] = $urandom_range(15, 0);
            exp_wr.push_back('{i, pt_x[i], pt_y[i], 0, 0});
        end
        build_expected(m);
        RST = 1'b0;
        for (int i = 0; i < 40; i++) begin
            X = 4'(pt_x[i]);
            Y = 4'(pt_y[i]);
            @(negedge CLK);
        end
    endtask

    task automatic finish_test();
        for (int k = 0; k < 40000 && !DONE; k++) @(negedge CLK);
        check("done_timeout", DONE, 1);
        repeat (3) @(negedge CLK);
        check("done_held", DONE, 1);
        check("ops_left", exp_op.size(), 0);
        check("fin_left", exp_fin.size(), 0);
    endtask

    initial begin : main
        // Single peak at (5,7) only while C2 sits at its start position.
        start_test(0, 1, 0);
        finish_test();
        check("peak_c1", {C1X, C1Y}, 5 * 16 + 7);
        check("peak_c2", {C2X, C2Y}, 15 * 16 + 15);
        check("peak_starts", mon_starts, 1024);

        start_test(1, 1, 0);
        finish_test();
        check("tie_c1", {C1X, C1Y}, 3 * 16 + 3);

        start_test(2, 1, 0);
        finish_test();
        check("forced_starts", mon_starts, 4096);

        start_test(3, 1, 0);
        finish_test();

        start_test(3, 5, 1);
        finish_test();

        // Asynchronous reset while waiting on candidate 100 of sweep 2.
        start_test(3, 3, 0);
        begin
            int k;
            for (k = 0; k < 20000; k++) begin
                @(negedge CLK);
                #1;
                if (mon_starts >= 357) break;
            end
            check("rst_wait_timeout", (mon_starts >= 357) ? 1 : 0, 1);
        end
        check("pre_rst_start", bus.eng_start, 1);
        check("pre_rst_cand", {bus.eng_cx, bus.eng_cy}, 4 * 16 + 6);
        #1;
        RST = 1'b1;
        #1;
        check("async_eng", {bus.eng_start, bus.eng_cx, bus.eng_cy, bus.eng_fx, bus.eng_fy}, 0);
        check("async_out", {C1X, C1Y, C2X, C2Y, DONE}, 0);
        check("async_wr", bus.pt_wr_en, 0);
        start_test(3, 2, 0);
        finish_test();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
